funciones_chk: RTL

Self-checking stimulus/response block for the six-output combinational gate-function unit (inputs a, b, c; outputs s1..s6). It drives the unit's inputs through all 8 combinations, waits a programmable settle time, samples the six outputs, and compares them against an internal golden model. It sits on the opposite side of that unit's interface from the logic: it drives a/b/c and reads s1..s6. Results are reported through a start/busy/done handshake with pass flag, per-vector error mask and error count.

---
 rtl/funciones_chk.sv | 130 +++++++++++++
 1 files changed

// File: rtl/funciones_chk.sv
// Stimulus/response checker for the six-output gate-function unit: sweeps {a,b,c}
// through all 8 vectors and compares s_in to a golden model. Optional: CHK_STOP_ON_FAIL_EN.
module funciones_chk #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic [5:0] s_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_mask,
  output logic [3:0] err_count
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_WAIT  | vector driven, settling for SETTLE cycles
  // S_CHECK | sample s_in and compare with golden
  // S_FIN   | one-cycle done pulse, pass latched on exit
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_FIN} state_t;

  localparam logic [3:0] LP_LAST_CNT = 4'(SETTLE - 1);

  state_t     r_state, w_state;
  logic [2:0] r_idx, w_idx;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_err_mask, w_err_mask;
  logic [3:0] r_err_count, w_err_count;
  logic       r_pass, w_pass;

  logic       w_a, w_b, w_c;
  logic [5:0] w_golden;
  logic       w_mismatch;

  assign w_a = r_idx[2];
  assign w_b = r_idx[1];
  assign w_c = r_idx[0];

  // Bit order matches s_in: bit 0 is s1, bit 5 is s6.
  assign w_golden = {(w_a & w_b) | w_c,
                     ~(w_a & w_c) | w_b,
                     ~(w_b | w_c),
                     ~(w_a ^ w_b),
                     w_a | w_b | w_c,
                     w_a ^ w_b ^ w_c};

  assign w_mismatch = (s_in != w_golden);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 4'd0;
      r_err_mask  <= 8'h00;
      r_err_count <= 4'd0;
      r_pass      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_cnt       <= w_cnt;
      r_err_mask  <= w_err_mask;
      r_err_count <= w_err_count;
      r_pass      <= w_pass;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_err_mask  = r_err_mask;
    w_err_count = r_err_count;
    w_pass      = r_pass;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state     = S_WAIT;
          w_idx       = 3'd0;
          w_cnt       = 4'd0;
          w_err_mask  = 8'h00;
          w_err_count = 4'd0;
          w_pass      = 1'b0;
        end
      end
      S_WAIT: begin
        if (r_cnt == LP_LAST_CNT) w_state = S_CHECK;
        else                      w_cnt   = r_cnt + 4'd1;
      end
      S_CHECK: begin
        if (w_mismatch) begin
          w_err_mask[r_idx] = 1'b1;
          w_err_count       = r_err_count + 4'd1;
        end
`ifdef CHK_STOP_ON_FAIL_EN
        if (w_mismatch || r_idx == 3'd7) begin
`else
        if (r_idx == 3'd7) begin
`endif
          w_state = S_FIN;
        end else begin
          w_idx   = r_idx + 3'd1;
          w_cnt   = 4'd0;
          w_state = S_WAIT;
        end
      end
      S_FIN: begin
        // err_count is already final here, including the last checked vector.
        w_pass  = (r_err_count == 4'd0);
        w_idx   = 3'd0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign a         = w_a;
  assign b         = w_b;
  assign c         = w_c;
  assign busy      = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done      = (r_state == S_FIN);
  assign pass      = r_pass;
  assign err_mask  = r_err_mask;
  assign err_count = r_err_count;

endmodule
